// File: rtl/add_share_arb.sv
// add_share_arb: round-robin scheduler sharing one registered adder between
// NREQ requesters. The granted requester's operands are summed (carry kept)
// into a one-entry response register tagged with the requester id.
//
// Optional feature macro: ADD_SHARE_ARB_STATS_EN adds per-requester 16-bit
// saturating grant counters readable through stat_sel/stat_cnt.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   stat_sel   counter select (stats build only)
//   stat_cnt   selected grant count, combinational (stats build only)
//   req_valid  per-requester operand valid
//   req_x      packed x operands, requester i at [i*WIDTH +: WIDTH]
//   req_y      packed y operands, same packing
//   req_ready  one-hot or zero grant, combinational
//   rsp_valid  response register holds a result
//   rsp_id     requester index of the held result
//   rsp_sum    x + y with carry
//   rsp_ready  consumer accepts the result
module add_share_arb #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef ADD_SHARE_ARB_STATS_EN
    input  logic [IDW-1:0]        stat_sel,
    output logic [15:0]           stat_cnt,
`endif
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_x,
    input  logic [NREQ*WIDTH-1:0] req_y,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH:0]        rsp_sum,
    input  logic                  rsp_ready
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [WIDTH:0] rsp_sum_q;

    logic           slot_free;
    logic           found;
    logic [IDW-1:0] gnt_id;
    logic [WIDTH:0] sum_d;

    assign slot_free = !rsp_valid_q || rsp_ready;

    // Search upward from ptr, wrapping, for the first valid requester.
    always_comb begin
        int unsigned idx;
        found  = 1'b0;
        gnt_id = '0;
        idx    = 0;
        if (slot_free) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = (32'(ptr_q) + k) % NREQ;
                if (!found && req_valid[idx]) begin
                    found  = 1'b1;
                    gnt_id = IDW'(idx);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    // Just-served requester drops to lowest priority.
    always_comb begin
        if (32'(gnt_id) + 1 >= NREQ) begin
            ptr_d = '0;
        end else begin
            ptr_d = gnt_id + IDW'(1);
        end
    end

    assign sum_d = {1'b0, req_x[32'(gnt_id)*WIDTH +: WIDTH]}
                 + {1'b0, req_y[32'(gnt_id)*WIDTH +: WIDTH]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
        end else begin
            if (found) begin
                // New result overwrites a retiring one with no bubble.
                ptr_q       <= ptr_d;
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= gnt_id;
                rsp_sum_q   <= sum_d;
            end else if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;

`ifdef ADD_SHARE_ARB_STATS_EN
    logic [15:0] cnt_q [NREQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (found && cnt_q[gnt_id] != 16'hFFFF) begin
            cnt_q[gnt_id] <= cnt_q[gnt_id] + 16'd1;
        end
    end

    always_comb begin
        stat_cnt = '0;
        if (32'(stat_sel) < NREQ) begin
            stat_cnt = cnt_q[stat_sel];
        end
    end
`endif

endmodule

// File: tb/tb_add_share_arb.sv
module tb_add_share_arb;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_x;
    logic [NREQ*WIDTH-1:0] req_y;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH:0]        rsp_sum;
    logic                  rsp_ready;
    logic [IDW-1:0]        stat_sel;
    logic [15:0]           stat_cnt;

    int checks;
    int errors;

    add_share_arb #(
        .NREQ (NREQ),
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef ADD_SHARE_ARB_STATS_EN
        .stat_sel (stat_sel),
        .stat_cnt (stat_cnt),
`endif
        .req_valid(req_valid),
        .req_x    (req_x),
        .req_y    (req_y),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_id   (rsp_id),
        .rsp_sum  (rsp_sum),
        .rsp_ready(rsp_ready)
    );

`ifndef ADD_SHARE_ARB_STATS_EN
    assign stat_cnt = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] x, input logic [7:0] y);
        req_x[i*WIDTH +: WIDTH] = x;
        req_y[i*WIDTH +: WIDTH] = y;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b0;
        stat_sel  = '0;
        #2;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b id=%0d sum=%0d, want 0/0/0",
                     rsp_valid, rsp_id, rsp_sum);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle_ready: got %b, want 0000", req_ready);
        end
        // ptr=0 during reset, so requester 0 wins.
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_ptr_zero: got %b, want 0001", req_ready);
        end
        req_valid = '0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        set_op(1, 8'd200, 8'd100);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL single_grant: got %b, want 0010", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 9'd300) begin
            errors++;
            $display("FAIL single_result: got valid=%b id=%0d sum=%0d, want 1/1/300",
                     rsp_valid, rsp_id, rsp_sum);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_retire: got valid=%b, want 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 8'(10 * i + 1), 8'(i + 5));
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] exp_rdy;
            int         id;
            id      = k % 4;
            exp_rdy = 4'b0001 << id;
            #1;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_grant_%0d: got %b, want %b", k, req_ready, exp_rdy);
            end
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(id) || rsp_sum !== 9'(11 * id + 6)) begin
                errors++;
                $display("FAIL rr_result_%0d: got valid=%b id=%0d sum=%0d, want 1/%0d/%0d",
                         k, rsp_valid, rsp_id, rsp_sum, id, 11 * id + 6);
            end
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_op(0, 8'd7, 8'd8);
        set_op(1, 8'd20, 8'd30);
        set_op(2, 8'd1, 8'd1);
        set_op(3, 8'd2, 8'd2);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_ready_low: got %b, want 0000", req_ready);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 9'd15 ||
                req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold_%0d: got valid=%b id=%0d sum=%0d rdy=%b, want 1/0/15/0000",
                         k, rsp_valid, rsp_id, rsp_sum, req_ready);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release_grant: got %b, want 0010", req_ready);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 9'd50) begin
            errors++;
            $display("FAIL bp_no_bubble: got valid=%b id=%0d sum=%0d, want 1/1/50",
                     rsp_valid, rsp_id, rsp_sum);
        end
        req_valid = '0;
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got valid=%b, want 0", rsp_valid);
        end
    endtask

    task automatic test_max_wrap();
        do_reset();
        set_op(3, 8'd255, 8'd255);
        set_op(0, 8'd1, 8'd2);
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL max_grant: got %b, want 1000", req_ready);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== 9'd510) begin
            errors++;
            $display("FAIL max_sum: got valid=%b id=%0d sum=%0d, want 1/3/510",
                     rsp_valid, rsp_id, rsp_sum);
        end
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_grant: got %b, want 0001", req_ready);
        end
        step();
        req_valid = 4'b1000;
        checks++;
        if (rsp_id !== 2'd0 || rsp_sum !== 9'd3) begin
            errors++;
            $display("FAIL wrap_result: got id=%0d sum=%0d, want 0/3", rsp_id, rsp_sum);
        end
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_next: got %b, want 1000", req_ready);
        end
        step();
        req_valid = '0;
        step();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) set_op(i, 8'(i), 8'(i));
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        step();
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pending: got valid=%b, want 1", rsp_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 9'd0) begin
            errors++;
            $display("FAIL mid_async_clear: got valid=%b sum=%0d, want 0/0", rsp_valid, rsp_sum);
        end
        req_valid = 4'b1110;
        rsp_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL mid_first_grant: got %b, want 0010", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 9'd2) begin
            errors++;
            $display("FAIL mid_result: got valid=%b id=%0d sum=%0d, want 1/1/2",
                     rsp_valid, rsp_id, rsp_sum);
        end
        step();
    endtask

`ifdef ADD_SHARE_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        set_op(2, 8'd3, 8'd4);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        repeat (5) step();
        req_valid = '0;
        stat_sel  = 2'd2;
        #1;
        checks++;
        if (stat_cnt !== 16'd5) begin
            errors++;
            $display("FAIL stats_count5: got %0d, want 5", stat_cnt);
        end
        req_valid = 4'b0100;
        repeat (70000) step();
        req_valid = '0;
        #1;
        checks++;
        if (stat_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL stats_saturate: got %h, want ffff", stat_cnt);
        end
        stat_sel = 2'd3;
        #1;
        checks++;
        if (stat_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stats_unused: got %0d, want 0", stat_cnt);
        end
        step();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_max_wrap();
        test_reset_mid();
`ifdef ADD_SHARE_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
